// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register; one fetch per cycle on zero-wait memory.
// Branch redirect squashes IF/ID; an abandoned in-flight request is drained before refetch.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        addermuxselect,
  input  logic        flush,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] drain_addr_q, drain_addr_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        hold_valid_q, hold_valid_d;
  logic [63:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        complete;
  logic        redirect;
  logic [63:0] new_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      drain_addr_q  <= 64'h0;
      hold_pc_q     <= 64'h0;
      hold_instr_q  <= NOP_INSTR;
      hold_valid_q  <= 1'b0;
      if_id_pc_q    <= 64'h0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_valid_q  <= hold_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  always_comb begin
    complete      = imem_req & imem_ready;
    redirect      = flush | addermuxselect;
    new_pc        = addermuxselect ? (branch_target & ~64'h3) : pc_q;
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;
    hold_valid_d  = hold_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    if (redirect) begin
      // Squash wins over stall; an unfinished FETCH request must still be drained.
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      hold_valid_d  = 1'b0;
      pc_d          = new_pc;
      if (state_q == FETCH && imem_req && !imem_ready) begin
        drain_addr_d = imem_addr;
        state_d      = DRAIN;
      end else if (complete) begin
        state_d = FETCH;
      end
    end else if (state_q == DRAIN) begin
      if (complete) state_d = FETCH;
      if (!stall) if_id_valid_d = 1'b0;
    end else if (hold_valid_q) begin
      if (!stall) begin
        if_id_pc_d    = hold_pc_q;
        if_id_instr_d = hold_instr_q;
        if_id_valid_d = 1'b1;
        hold_valid_d  = 1'b0;
      end
    end else if (complete) begin
      pc_d = pc_q + 64'd4;
      if (stall) begin
        hold_pc_d    = pc_q;
        hold_instr_d = imem_rdata;
        hold_valid_d = 1'b1;
      end else begin
        if_id_pc_d    = pc_q;
        if_id_instr_d = imem_rdata;
        if_id_valid_d = 1'b1;
      end
    end else if (!stall) begin
      // Decode consumed the last instruction and nothing replaced it.
      if_id_valid_d = 1'b0;
    end
  end

  always_comb begin
    imem_req  = !reset && (state_q == DRAIN || !hold_valid_q);
    imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  end

  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage with an address-derived instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, addermuxselect, flush, imem_ready;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .addermuxselect(addermuxselect),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  always_comb imem_rdata = 32'hC000_0000 | imem_addr[31:0];

  typedef struct {
    logic        rst, stl, ams, fl;
    logic [63:0] bt;
    logic        rdy;
    logic        req;
    logic [63:0] addr;
    logic        v;
    logic [63:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, stl, ams, fl, input logic [63:0] bt, input logic rdy,
                     input logic req, input logic [63:0] addr, input logic v,
                     input logic [63:0] pc, input logic [31:0] ins);
    vec_t t;
    t.rst = rst; t.stl = stl; t.ams = ams; t.fl = fl; t.bt = bt; t.rdy = rdy;
    t.req = req; t.addr = addr; t.v = v; t.pc = pc; t.ins = ins;
    vq.push_back(t);
  endtask

  initial begin
    logic [63:0] exp_pc;
    int          cyc;
    logic        seen;

    reset = 1'b1; stall = 1'b0; addermuxselect = 1'b0; flush = 1'b0;
    branch_target = 64'h0; imem_ready = 1'b0;
    @(posedge clk); #1;

    //   rst stl ams fl  bt                      rdy  req addr                    v  if_id_pc                ins
    add(1, 0, 0, 0, 64'h0,                  1,   0, 64'h0,                  0, 64'h0,                  NOP);          // 0 reset
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h0,                  1, 64'h0,                  32'hC000_0000);
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h4,                  1, 64'h4,                  32'hC000_0004);
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h8,                  1, 64'h8,                  32'hC000_0008);
    add(0, 0, 1, 1, 64'h100,                1,   1, 64'hC,                  0, 64'h8,                  NOP);          // 4 branch
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h100,                1, 64'h100,                32'hC000_0100);
    add(0, 0, 1, 0, 64'h103,                1,   1, 64'h104,                0, 64'h100,                NOP);          // 6 misaligned target
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h100,                1, 64'h100,                32'hC000_0100);
    add(0, 1, 0, 0, 64'h0,                  1,   1, 64'h104,                1, 64'h100,                32'hC000_0100); // 8 stall
    add(0, 1, 0, 0, 64'h0,                  1,   0, 64'h108,                1, 64'h100,                32'hC000_0100);
    add(0, 1, 0, 0, 64'h0,                  1,   0, 64'h108,                1, 64'h100,                32'hC000_0100);
    add(0, 0, 0, 0, 64'h0,                  1,   0, 64'h108,                1, 64'h104,                32'hC000_0104); // 11 release
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h108,                1, 64'h108,                32'hC000_0108);
    add(0, 1, 0, 0, 64'h0,                  1,   1, 64'h10C,                1, 64'h108,                32'hC000_0108);
    add(0, 1, 0, 1, 64'h0,                  0,   0, 64'h110,                0, 64'h108,                NOP);          // 14 stall+flush
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h110,                1, 64'h110,                32'hC000_0110);
    add(0, 0, 1, 1, 64'h200,                0,   1, 64'h114,                0, 64'h110,                NOP);          // 16 redirect mid-wait
    add(0, 0, 0, 0, 64'h0,                  0,   1, 64'h114,                0, 64'h110,                NOP);
    add(0, 0, 0, 0, 64'h0,                  0,   1, 64'h114,                0, 64'h110,                NOP);
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h114,                0, 64'h110,                NOP);          // 19 drained
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h200,                1, 64'h200,                32'hC000_0200);
    add(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1,  1, 64'h204,                0, 64'h200,                NOP);          // 21 to top
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC);
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h0,                  1, 64'h0,                  32'hC000_0000); // 23 wrap
    add(0, 0, 1, 1, 64'h300,                0,   1, 64'h4,                  0, 64'h0,                  NOP);          // 24 enter DRAIN
    add(0, 0, 1, 0, 64'h400,                0,   1, 64'h4,                  0, 64'h0,                  NOP);
    add(1, 0, 0, 0, 64'h0,                  1,   0, 64'h4,                  0, 64'h0,                  NOP);          // 26 reset in DRAIN
    add(0, 0, 0, 0, 64'h0,                  1,   1, 64'h0,                  1, 64'h0,                  32'hC000_0000);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; stall = vq[i].stl; addermuxselect = vq[i].ams; flush = vq[i].fl;
      branch_target = vq[i].bt; imem_ready = vq[i].rdy;
      #1;
      chk("imem_req",  i, {63'h0, imem_req}, {63'h0, vq[i].req});
      chk("imem_addr", i, imem_addr, vq[i].addr);
      @(posedge clk); #1;
      chk("if_id_valid", i, {63'h0, if_id_valid}, {63'h0, vq[i].v});
      chk("if_id_pc",    i, if_id_pc, vq[i].pc);
      chk("if_id_instr", i, {32'h0, if_id_instr}, {32'h0, vq[i].ins});
    end

    // Free-running zero-wait fetch: consecutive PCs with no gaps.
    exp_pc = 64'h4;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      reset = 1'b0; stall = 1'b0; addermuxselect = 1'b0; flush = 1'b0; imem_ready = 1'b1;
      @(posedge clk); #1;
      chk("run_valid", 100 + k, {63'h0, if_id_valid}, 64'h1);
      chk("run_pc",    100 + k, if_id_pc, exp_pc);
      chk("run_instr", 100 + k, {32'h0, if_id_instr}, {32'h0, 32'hC000_0000 | exp_pc[31:0]});
      exp_pc = exp_pc + 64'd4;
    end

    // Slow memory: ready after three wait cycles; IF/ID must bubble then deliver the next PC.
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 12) begin
      @(negedge clk);
      imem_ready = (cyc == 3);
      @(posedge clk); #1;
      if (cyc < 3) chk("slow_bubble", 200 + cyc, {63'h0, if_id_valid}, 64'h0);
      if (if_id_valid) seen = 1'b1;
      cyc++;
    end
    chk("slow_arrived", 300, {63'h0, seen}, 64'h1);
    chk("slow_pc",      301, if_id_pc, exp_pc);
    chk("slow_cycles",  302, 64'(cyc), 64'd4);

    @(negedge clk);
    imem_ready = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
